// File: rtl/button_cmd_encoder_pkg.sv
// button_cmd_encoder_pkg: shared press-FSM state encoding and direction constants
package button_cmd_encoder_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD_UP = 2'd1,
    HOLD_DN = 2'd2,
    LOCK    = 2'd3
  } state_t;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;
endpackage

// File: rtl/button_cmd_encoder_btn_debounce.sv
// btn_debounce: two-flop synchroniser followed by a tick-sampled hold-count debounce
module btn_debounce #(
  parameter int DEB_TICKS = 4,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn_i,
  output logic deb_o
);
  localparam logic [CNT_W-1:0] DEB_N = CNT_W'(DEB_TICKS);
  logic [1:0]       sync_q;
  logic             deb_q, deb_d, diff, done;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  always_comb begin
    cnt_inc = cnt_q + 1'b1;
    diff    = sync_q[1] != deb_q;
    done    = tick && diff && cnt_inc == DEB_N;
    cnt_d   = !tick ? cnt_q : (!diff || done) ? '0 : cnt_inc;
    deb_d   = done ? ~deb_q : deb_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end
  assign deb_o = deb_q;
endmodule

// File: rtl/button_cmd_encoder.sv
// button_cmd_encoder: debounced two-button press FSM producing counter enable/direction commands
module button_cmd_encoder
  import button_cmd_encoder_pkg::*;
#(
  parameter int DEB_TICKS    = 4,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 4,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic button1,
  input  logic button2,
  output logic enable,
  output logic up_down,
  output logic locked
);
  localparam logic [CNT_W-1:0] DELAY_N = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RATE_N  = CNT_W'(REPEAT_RATE);
  logic             d1, d2, own, other, step;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] rpt_q, rpt_d;
  logic             en_q, en_d, dir_q, dir_d;
  btn_debounce #(.DEB_TICKS(DEB_TICKS), .CNT_W(CNT_W)) u_btn1 (
    .clk(clk), .reset(reset), .tick(tick), .btn_i(button1), .deb_o(d1)
  );
  btn_debounce #(.DEB_TICKS(DEB_TICKS), .CNT_W(CNT_W)) u_btn2 (
    .clk(clk), .reset(reset), .tick(tick), .btn_i(button2), .deb_o(d2)
  );
  // repeat countdown pauses while a pulse is out so enable never stays high two cycles
  always_comb begin
    state_d = state_q;
    rpt_d   = rpt_q;
    en_d    = 1'b0;
    dir_d   = dir_q;
    own     = state_q == HOLD_UP ? d1 : d2;
    other   = state_q == HOLD_UP ? d2 : d1;
    step    = tick && rpt_q != '0 && !en_q;
    case (state_q)
      IDLE: begin
        if (d1 && d2) begin
          state_d = LOCK;
        end else if (d1 || d2) begin
          state_d = d1 ? HOLD_UP : HOLD_DN;
          en_d    = 1'b1;
          dir_d   = d1 ? DIR_UP : DIR_DN;
          rpt_d   = DELAY_N;
        end
      end
      HOLD_UP, HOLD_DN: begin
        if (other) begin
          state_d = LOCK;
        end else if (!own) begin
          state_d = IDLE;
        end else if (step) begin
          en_d  = rpt_q == CNT_W'(1);
          dir_d = rpt_q == CNT_W'(1) ? (state_q == HOLD_UP ? DIR_UP : DIR_DN) : dir_q;
          rpt_d = rpt_q == CNT_W'(1) ? RATE_N : rpt_q - 1'b1;
        end
      end
      default: state_d = (d1 || d2) ? LOCK : IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rpt_q   <= '0;
      en_q    <= 1'b0;
      dir_q   <= DIR_UP;
    end else begin
      state_q <= state_d;
      rpt_q   <= rpt_d;
      en_q    <= en_d;
      dir_q   <= dir_d;
    end
  end
  assign enable  = en_q;
  assign up_down = dir_q;
  assign locked  = state_q == LOCK;
endmodule
